// File: rtl/msrv32_pipe_skid_reg.sv
// msrv32_pipe_skid_reg: pipeline register with valid/ready handshake.
// SKID=1 gives a two-entry skid stage whose ready_out is a flop, which
// breaks the ready_in -> ready_out timing path. SKID=0 gives a single
// register with combinational ready_out.
// Optional feature: define MSRV32_PIPE_STALL_CNT_EN to build the 16-bit
// saturating back-pressure counter. Without it, stall_cnt_out is tied to 0.

module msrv32_pipe_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    input  logic              flush_in,
    output logic [15:0]       stall_cnt_out
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Handshake qualifiers. A flush blocks that cycle's upstream transfer.
    logic up_xfer_c;
    logic dn_xfer_c;

    assign up_xfer_c = valid_in & ready_out & ~flush_in;
    assign dn_xfer_c = valid_out & ready_in;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e       state;
            logic [DATA_W-1:0] skid_q;

            // Two-entry skid FSM. data_out is the main entry and skid_q
            // catches the word accepted while downstream stalls.
            // ready_out is low only in ST_TWO.
            always_ff @(posedge clk_in or negedge reset_n_in) begin
                if (!reset_n_in) begin
                    state     <= ST_EMPTY;
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    data_out  <= '0;
                    skid_q    <= '0;
                end else if (flush_in) begin
                    state     <= ST_EMPTY;
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (up_xfer_c) begin
                                data_out  <= data_in;
                                valid_out <= 1'b1;
                                state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (up_xfer_c && dn_xfer_c) begin
                                data_out <= data_in;
                            end else if (up_xfer_c) begin
                                skid_q    <= data_in;
                                ready_out <= 1'b0;
                                state     <= ST_TWO;
                            end else if (dn_xfer_c) begin
                                valid_out <= 1'b0;
                                state     <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (dn_xfer_c) begin
                                data_out  <= skid_q;
                                ready_out <= 1'b1;
                                state     <= ST_ONE;
                            end
                        end
                        default: begin
                            state     <= ST_EMPTY;
                            valid_out <= 1'b0;
                            ready_out <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_reg
            // The stage can take a new word when it is empty, or when the
            // held word leaves in the same cycle.
            assign ready_out = ~valid_out | ready_in;

            // Single register stage: it reloads on every upstream transfer.
            always_ff @(posedge clk_in or negedge reset_n_in) begin
                if (!reset_n_in) begin
                    valid_out <= 1'b0;
                    data_out  <= '0;
                end else if (flush_in) begin
                    valid_out <= 1'b0;
                end else if (up_xfer_c) begin
                    data_out  <= data_in;
                    valid_out <= 1'b1;
                end else if (dn_xfer_c) begin
                    valid_out <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef MSRV32_PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Count the edges where a valid word is stalled. The count saturates
    // at all-ones and clears only on reset.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cnt_q <= '0;
        end else if (valid_out && !ready_in && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`else
    assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_pipe_skid_reg.sv
// Bench for msrv32_pipe_skid_reg. One SKID=1 instance and one SKID=0
// instance share the same inputs. Each instance is compared against a
// queue-based occupancy model of the stage.

module tb_msrv32_pipe_skid_reg;

    localparam int unsigned DATA_W = 64;

    logic              clk_in;
    logic              reset_n_in;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              flush_in;

    logic              ready_out1, valid_out1;
    logic [DATA_W-1:0] data_out1;
    logic [15:0]       stall1;
    logic              ready_out0, valid_out0;
    logic [DATA_W-1:0] data_out0;
    logic [15:0]       stall0;

    int n_vec;
    int n_err;

    // Model state: the words held by each stage, oldest first, plus the
    // expected stall count for each stage.
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q0[$];
    int                cnt1;
    int                cnt0;

    msrv32_pipe_skid_reg #(.DATA_W(DATA_W), .SKID(1)) u_dut_skid (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (ready_out1),
        .valid_out     (valid_out1),
        .data_out      (data_out1),
        .ready_in      (ready_in),
        .flush_in      (flush_in),
        .stall_cnt_out (stall1)
    );

    msrv32_pipe_skid_reg #(.DATA_W(DATA_W), .SKID(0)) u_dut_reg (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (ready_out0),
        .valid_out     (valid_out0),
        .data_out      (data_out0),
        .ready_in      (ready_in),
        .flush_in      (flush_in),
        .stall_cnt_out (stall0)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic check_outputs();
        chk("valid1", 64'(valid_out1), 64'(q1.size() > 0));
        if (q1.size() > 0) chk("data1", data_out1, q1[0]);
        chk("ready1", 64'(ready_out1), 64'(q1.size() < 2));
        chk("stall1", 64'(stall1), 64'(cnt1));
        chk("valid0", 64'(valid_out0), 64'(q0.size() > 0));
        if (q0.size() > 0) chk("data0", data_out0, q0[0]);
        chk("ready0", 64'(ready_out0), 64'((q0.size() == 0) || ready_in));
        chk("stall0", 64'(stall0), 64'(cnt0));
    endtask

    // Drive one cycle of inputs at the falling edge, check the outputs,
    // then advance the model over the coming rising edge.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r, input logic f);
        bit up1, dn1, up0, dn0;
        @(negedge clk_in);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush_in = f;
        #1;
        check_outputs();
        up1 = v && (q1.size() < 2) && !f;
        dn1 = (q1.size() > 0) && r;
        up0 = v && ((q0.size() == 0) || r) && !f;
        dn0 = (q0.size() > 0) && r;
`ifdef MSRV32_PIPE_STALL_CNT_EN
        if (q1.size() > 0 && !r && cnt1 < 65535) cnt1++;
        if (q0.size() > 0 && !r && cnt0 < 65535) cnt0++;
`endif
        if (f) begin
            q1.delete();
            q0.delete();
        end else begin
            if (dn1) void'(q1.pop_front());
            if (up1) q1.push_back(d);
            if (dn0) void'(q0.pop_front());
            if (up0) q0.push_back(d);
        end
    endtask

    task automatic clear_model();
        q1.delete();
        q0.delete();
        cnt1 = 0;
        cnt0 = 0;
    endtask

    // Synchronous-looking reset held over two rising edges, then checked.
    task automatic do_reset();
        @(negedge clk_in);
        reset_n_in = 1'b0;
        valid_in   = 1'b0;
        flush_in   = 1'b0;
        ready_in   = 1'b0;
        clear_model();
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        chk("rst_valid1", 64'(valid_out1), 64'd0);
        chk("rst_data1", data_out1, 64'd0);
        chk("rst_stall1", 64'(stall1), 64'd0);
        chk("rst_valid0", 64'(valid_out0), 64'd0);
        chk("rst_data0", data_out0, 64'd0);
        chk("rst_ready0", 64'(ready_out0), 64'd1);
        reset_n_in = 1'b1;
    endtask

    // Fill the SKID=1 stage to two entries with downstream stalled.
    task automatic fill_two(input logic [63:0] a, input logic [63:0] b);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n_in = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        ready_in   = 1'b0;
        flush_in   = 1'b0;
        clear_model();

        // Single transfer into an empty stage appears one cycle later.
        do_reset();
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("ready1_after_rst", 64'(ready_out1), 64'd1);
        cycle(1'b1, 64'h12345678_AABBCCDD, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("first_valid", 64'(valid_out1), 64'd1);
        chk("first_data", data_out1, 64'h12345678_AABBCCDD);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Two words pile up under back-pressure, then drain in order.
        do_reset();
        fill_two(64'h1000, 64'h1004);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        chk("two_ready", 64'(ready_out1), 64'd0);
        chk("two_hold", data_out1, 64'h1000);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("drain_a", data_out1, 64'h1000);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("drain_b", data_out1, 64'h1004);
        chk("drain_ready", 64'(ready_out1), 64'd1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // A flush in state TWO kills both entries and blocks the new word.
        do_reset();
        fill_two(64'h2000, 64'h2004);
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("flush_valid", 64'(valid_out1), 64'd0);
        chk("flush_ready", 64'(ready_out1), 64'd1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // The single-register stage streams with no bubbles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 64'(i), 1'b1, 1'b0);
            if (i > 0) chk("stream0", data_out0, 64'(i - 1));
        end
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        chk("stream0_last", data_out0, 64'd9);
        chk("stall_ready0", 64'(ready_out0), 64'd0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Stall counter: 5 stalled edges, then saturation.
        do_reset();
        cycle(1'b1, 64'h55, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
`ifdef MSRV32_PIPE_STALL_CNT_EN
        chk("stall5", 64'(stall1), 64'd5);
        for (int i = 0; i < 70000; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall1), 64'hFFFF);
`else
        chk("stall_off", 64'(stall1), 64'd0);
`endif

        // Asynchronous reset between edges while in state TWO.
        do_reset();
        fill_two(64'h3000, 64'h3004);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("arst_valid1", 64'(valid_out1), 64'd0);
        chk("arst_data1", data_out1, 64'd0);
        chk("arst_stall1", 64'(stall1), 64'd0);
        chk("arst_valid0", 64'(valid_out0), 64'd0);
        chk("arst_data0", data_out0, 64'd0);
        clear_model();
        @(negedge clk_in);
        reset_n_in = 1'b1;
        valid_in   = 1'b0;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/msrv32_pipe_skid_reg.md
MSRV32_PIPE_SKID_REG -- requirements
Module: msrv32_pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits (legal 1..256).
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid stage with registered ready; 0 = single register with combinational ready.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in  input  1  upstream payload valid.
REQ-006 SHALL have port data_in  input  DATA_W  upstream payload (packed rd/csr/rs1/rs2/pc/imm/control fields).
REQ-007 SHALL have port ready_out  output  1  stage can accept data_in this cycle.
REQ-008 SHALL have port valid_out  output  1  downstream payload valid.
REQ-009 SHALL have port data_out  output  DATA_W  downstream payload.
REQ-010 SHALL have port ready_in  input  1  downstream accepts data_out this cycle.
REQ-011 SHALL have port flush_in  input  1  synchronous kill of all held entries (branch taken/trap).
REQ-012 SHALL have port stall_cnt_out  output  16  back-pressure cycle counter.

Function
REQ-013 Upstream transfer SHALL occur on a rising edge where valid_in=1, ready_out=1 and flush_in=0; downstream transfer where valid_out=1 and ready_in=1.
REQ-014 Latency from upstream transfer into an empty stage to valid_out=1 with that payload SHALL be exactly 1 cycle.
REQ-015 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable.
REQ-016 Payloads SHALL leave in acceptance order; none duplicated or dropped except by flush_in or reset.
REQ-017 SKID=1 SHALL implement states EMPTY (no entries), ONE (main entry valid), TWO (main and skid valid).
REQ-018 SKID=1 transitions: EMPTY->ONE on upstream transfer; ONE->EMPTY on downstream transfer without upstream transfer; ONE->ONE on simultaneous transfers (main reloads); ONE->TWO on upstream transfer with ready_in=0; TWO->ONE on downstream transfer (skid moves to main).
REQ-019 SKID=1: ready_out SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO; no combinational path from ready_in to ready_out.
REQ-020 SKID=0: ready_out SHALL equal (~valid_out | ready_in) combinationally; main register loads on every upstream transfer.
REQ-021 flush_in=1 SHALL, at the next edge, clear all entry valids (state EMPTY), block that cycle's upstream transfer, and take priority over any simultaneous transfer; data registers may retain old values.
REQ-022 During the cycle flush_in=1, outputs SHALL retain their current values; a downstream transfer in that cycle still completes.
REQ-023 Data registers SHALL load only on an accepting transfer (no enable-less toggling).

Reset
REQ-024 reset_n_in low SHALL immediately force valid_out=0, all entry valids=0, data_out=0, stall_cnt_out=0, state EMPTY.
REQ-025 After reset release, ready_out SHALL be 1 (SKID=1: from the first edge; SKID=0: combinationally).
REQ-026 Reset asserted mid-transfer SHALL discard all held payloads; no transfer completes on that edge.

Configuration
REQ-027 Macro MSRV32_PIPE_STALL_CNT_EN defined: stall_cnt_out SHALL increment by 1 each edge where valid_out=1 and ready_in=0, saturate at 16'hFFFF, clear only on reset.
REQ-028 Macro MSRV32_PIPE_STALL_CNT_EN undefined: stall_cnt_out SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-029 SKID=1, reset low then high, valid_in=1 data_in=64'h12345678_AABBCCDD, ready_in=1 -> valid_out=1, data_out=64'h12345678_AABBCCDD one cycle after accept.
REQ-030 SKID=1, ready_in=0, push A=64'h1000 then B=64'h1004 -> ready_out=0 after B, data_out=64'h1000 held; ready_in=1 -> 64'h1000 then 64'h1004 on consecutive cycles, ready_out returns to 1.
REQ-031 SKID=1, state TWO, flush_in=1 with valid_in=1 data_in=64'hDEAD -> next cycle valid_out=0, ready_out=1, 64'hDEAD never appears at data_out.
REQ-032 SKID=0, ready_in=0 with valid_out=1 -> ready_out=0 same cycle; ready_in=1 -> ready_out=1 same cycle, continuous streaming 64'h0..64'h9 with no bubbles.
REQ-033 MSRV32_PIPE_STALL_CNT_EN defined, hold valid_out=1, ready_in=0 for 5 cycles -> stall_cnt_out=5; force 70000 stalled cycles -> stall_cnt_out=16'hFFFF.
REQ-034 reset_n_in low mid-stream in state TWO, asynchronously between edges -> valid_out=0, data_out=0, stall_cnt_out=0 before the next edge.
